// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte producers.
// Frames are timed internally since uart_tx exposes no completion flag.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned DW           = 8,
  parameter int unsigned CLOCK        = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned BAUD_COUNTER = CLOCK / BAUD_RATE,
  parameter int unsigned FRAME_BITS   = DW + 2,
  parameter int unsigned FRAME_CYCLES = BAUD_COUNTER * FRAME_BITS,
  parameter int unsigned GAP_CYCLES   = BAUD_COUNTER
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*DW-1:0]      req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    cs_o,
  output logic [DW-1:0]           data_o,
  output logic                    byte_ready_o,
  output logic                    t_byte_o,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] grant_id_o
);

  localparam int unsigned IW   = $clog2(NREQ);
  localparam int unsigned CMAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [DW-1:0] data_q, data_d;

  logic [IW-1:0] pick, pick_hi, pick_lo;
  logic          found_hi, found_lo;
  logic [DW-1:0] pick_data;
  logic          accept;

  // Two-pass priority search: first valid at or above rr_q, else lowest below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        if (IW'(i) >= rr_q) begin
          found_hi = 1'b1;
          pick_hi  = IW'(i);
        end else begin
          found_lo = 1'b1;
          pick_lo  = IW'(i);
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  assign accept = (state_q == StIdle) && en_i && (found_hi || found_lo);

  always_comb begin
    pick_data   = '0;
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == pick) begin
        pick_data      = req_data_i[i*DW +: DW];
        req_ready_o[i] = accept;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = pick_data;
          gid_d   = pick;
          rr_d    = (pick == IW'(NREQ - 1)) ? '0 : pick + IW'(1);
          state_d = StLoad;
        end
      end
      StLoad:  state_d = StStart;
      StStart: begin
        cnt_d   = CW'(FRAME_CYCLES - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rr_q    <= '0;
      gid_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset idles the line at once.
  assign busy_o       = (state_q != StIdle);
  assign cs_o         = busy_o;
  assign byte_ready_o = (state_q == StLoad);
  assign t_byte_o     = (state_q == StStart);
  assign data_o       = data_q;
  assign grant_id_o   = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected (grant, byte) frames queued at stimulus time.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ      = 2;
  localparam int unsigned DW        = 8;
  localparam int unsigned FRAME_CYC = 40;
  localparam int unsigned GAP_CYC   = 4;
  localparam int unsigned BUSY_LEN  = 2 + FRAME_CYC + GAP_CYC;
  // Back-to-back accepts are separated by the busy run plus the IDLE accept cycle.
  localparam int unsigned ACC_SPACE = BUSY_LEN + 1;

  typedef struct {
    logic [0:0]    id;
    logic [DW-1:0] data;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              cs, byte_ready, t_byte, busy;
  logic [DW-1:0]     data;
  logic [0:0]        grant_id;

  frame_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  int      cyc = 0;
  int      acc_cnt = 0;
  int      last_acc = 0;
  bit      mon_en = 1'b0;
  bit      chk_sp = 1'b0;
  bit      sp_have = 1'b0;
  int      busy_run = 0;
  logic    prev_busy = 1'b0;
  logic    prev_br = 1'b0;
  logic [DW-1:0] cur_data = '0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ         (NREQ),
    .DW           (DW),
    .BAUD_COUNTER (4),
    .FRAME_CYCLES (FRAME_CYC),
    .GAP_CYCLES   (GAP_CYC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .en_i         (en),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .cs_o         (cs),
    .data_o       (data),
    .byte_ready_o (byte_ready),
    .t_byte_o     (t_byte),
    .busy_o       (busy),
    .grant_id_o   (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [0:0] id, input logic [DW-1:0] d);
    frame_t f;
    f.id   = id;
    f.data = d;
    exp_q.push_back(f);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      tick(1);
      if (!busy) break;
    end
    if (k == 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_acc(input int n);
    int target;
    int k;
    target = acc_cnt + n;
    for (k = 0; k < 400; k++) begin
      if (acc_cnt >= target) break;
      tick(1);
    end
    if (acc_cnt < target) chk("accept_timeout", 32'(acc_cnt), 32'(target));
  endtask

  // Monitor: pops the scoreboard on each byte_ready and checks frame timing.
  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      busy_run  = 0;
      prev_busy = 1'b0;
      prev_br   = 1'b0;
    end else begin
      if ((req_ready & req_valid) != '0) begin
        if (chk_sp && sp_have) chk("accept_spacing", 32'(cyc - last_acc), ACC_SPACE);
        sp_have  = 1'b1;
        last_acc = cyc;
        acc_cnt++;
      end
      chk("t_byte_follows", {31'd0, t_byte}, {31'd0, prev_br});
      if (byte_ready) begin
        chk("accept_latency", 32'(cyc - last_acc), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          chk("frame_data", {24'd0, data}, {24'd0, f.data});
          chk("frame_grant", {31'd0, grant_id}, {31'd0, f.id});
          cur_data = f.data;
        end
      end else if (busy) begin
        chk("data_stable", {24'd0, data}, {24'd0, cur_data});
      end
      if (busy) begin
        chk("ready_while_busy", {30'd0, req_ready}, 32'd0);
        chk("cs_while_busy", {31'd0, cs}, 32'd1);
        busy_run++;
      end else if (prev_busy) begin
        chk("busy_length", 32'(busy_run), BUSY_LEN);
        busy_run = 0;
      end
      prev_busy = busy;
      prev_br   = byte_ready;
    end
  end

  initial begin
    int snap;
    rst_n     = 1'b0;
    en        = 1'b1;
    req_valid = '0;
    req_data  = '0;
    #1;
    chk("rst_cs", {31'd0, cs}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_strobes", {30'd0, byte_ready, t_byte}, 32'd0);
    tick(2);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Single byte from requester 0.
    push(1'b0, 8'hA5);
    req_data[7:0] = 8'hA5;
    req_valid     = 2'b01;
    #1;
    chk("single_ready", {30'd0, req_ready}, 32'd1);
    wait_acc(1);
    req_valid = '0;
    wait_idle();
    chk("single_grant", {31'd0, grant_id}, 32'd0);

    // Reset asserted mid-WAIT aborts the frame immediately.
    push(1'b0, 8'h3C);
    req_data[7:0] = 8'h3C;
    req_valid     = 2'b01;
    wait_acc(1);
    req_valid = '0;
    tick(22);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("abort_cs", {31'd0, cs}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_strobes", {30'd0, byte_ready, t_byte}, 32'd0);
    chk("abort_grant", {31'd0, grant_id}, 32'd0);
    tick(2);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(1);

    // Contention: rr pointer back at 0, grants alternate with no idle frames.
    push(1'b0, 8'h11);
    push(1'b1, 8'h22);
    push(1'b0, 8'h11);
    push(1'b1, 8'h22);
    req_data  = {8'h22, 8'h11};
    req_valid = 2'b11;
    sp_have   = 1'b0;
    chk_sp    = 1'b1;
    #1;
    chk("rr_after_reset", {30'd0, req_ready}, 32'd1);
    wait_acc(4);
    req_valid = '0;
    chk_sp    = 1'b0;
    wait_idle();

    // en_i dropped during WAIT: frame finishes, no new grant until re-enabled.
    push(1'b0, 8'h5A);
    req_data[7:0] = 8'h5A;
    req_valid     = 2'b01;
    wait_acc(1);
    req_valid = '0;
    tick(10);
    en             = 1'b0;
    req_data[15:8] = 8'h77;
    req_valid      = 2'b10;
    snap           = acc_cnt;
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      chk("ready_en_off", {30'd0, req_ready}, 32'd0);
      tick(1);
    end
    chk("no_accept_en_off", 32'(acc_cnt), 32'(snap));
    push(1'b1, 8'h77);
    en = 1'b1;
    #1;
    chk("ready_reenable", {30'd0, req_ready}, 32'd2);
    wait_acc(1);
    req_valid = '0;
    wait_idle();

    // Pointer wrap: req1 alone then req0 alone, back-to-back.
    push(1'b1, 8'hC3);
    push(1'b0, 8'h3D);
    req_data  = {8'hC3, 8'h3D};
    req_valid = 2'b10;
    sp_have   = 1'b0;
    chk_sp    = 1'b1;
    wait_acc(1);
    req_valid = 2'b01;
    wait_acc(1);
    req_valid = '0;
    chk_sp    = 1'b0;
    chk("wrap_grant", {31'd0, grant_id}, 32'd0);
    wait_idle();

    // Valid withdrawn while busy is never sampled.
    push(1'b1, 8'h99);
    req_data[15:8] = 8'h99;
    req_valid      = 2'b10;
    wait_acc(1);
    req_valid = '0;
    snap      = acc_cnt;
    tick(10);
    req_data[7:0] = 8'hEE;
    req_valid     = 2'b01;
    tick(1);
    req_valid = '0;
    wait_idle();
    tick(5);
    chk("withdrawn_not_taken", 32'(acc_cnt), 32'(snap));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
